// File: rtl/rx_tagger_pkg.sv
// Shared definitions for the RX length tagger: bus widths, TUSER field layout,
// read FSM encoding and the buffered beat format.
package rx_tagger_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned USER_W = 128;
    localparam int unsigned LEN_W  = 16;

    localparam int unsigned LEN_LO = 0;
    localparam int unsigned LEN_HI = 15;
    localparam int unsigned SRC_LO = 16;
    localparam int unsigned SRC_HI = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [STRB_W-1:0] tstrb;
        logic              tlast;
    } beat_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rx_axis_len_tagger_if.sv
// 64-bit AXI-Stream bus with 128-bit TUSER and an end-of-frame error sideband.
interface rx_axis_len_tagger_if;
    import rx_tagger_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              err;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, err, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, err, output tready);

endinterface

// File: rtl/rx_tagger_meta_fifo.sv
// Synchronous first-word-fall-through FIFO holding one length word per committed packet.
module rx_tagger_meta_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data_c,
    output logic             o_empty_c,
    output logic             o_full_nxt_c
);
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    assign w_full       = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign o_empty_c    = r_wr_ptr == r_rd_ptr;
    assign w_push_ok    = i_push & ~w_full;
    assign w_pop_ok     = i_pop & ~o_empty_c;
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push_ok);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop_ok);
    assign o_full_nxt_c = (w_wr_ptr_nxt - w_rd_ptr_nxt) == DEPTH_P;
    assign o_data_c     = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/rx_axis_len_tagger.sv
// Store-and-forward RX stage: buffers whole packets, drops bad/overflowed ones and
// re-emits good ones with length and source port in TUSER on the first beat.
module rx_axis_len_tagger
    import rx_tagger_pkg::*;
#(
    parameter int unsigned DATA_DEPTH_LOG2 = 9,
    parameter int unsigned META_DEPTH_LOG2 = 4,
    parameter logic [7:0]  SRC_PORT        = 8'h01
) (
    input  logic                        clk,
    input  logic                        reset,
    rx_axis_len_tagger_if.slave         s_axis,
    rx_axis_len_tagger_if.master        m_axis,
    output logic [31:0]                 pkt_good_cnt,
    output logic [31:0]                 pkt_drop_cnt
);
    localparam int unsigned PTR_W = DATA_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DATA_DEPTH_LOG2;
    localparam int unsigned SUM_W = LEN_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    beat_t r_mem [0:DEPTH-1];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_commit_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LEN_W-1:0]  r_byte_cnt;
    logic              r_ovf;
    logic              r_s_tready;
    logic [31:0]       r_good_cnt;
    logic [31:0]       r_drop_cnt;

    rd_state_e         r_state;
    rd_state_e         w_state_nxt;
    logic              r_m_tvalid;
    logic [DATA_W-1:0] r_m_tdata;
    logic [STRB_W-1:0] r_m_tstrb;
    logic              r_m_tlast;
    logic [USER_W-1:0] r_m_tuser;
    logic              w_tvalid_nxt;
    logic [DATA_W-1:0] w_tdata_nxt;
    logic [STRB_W-1:0] w_tstrb_nxt;
    logic              w_tlast_nxt;
    logic [USER_W-1:0] w_tuser_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_inc;

    logic              w_accept;
    logic              w_buf_full;
    logic              w_wr_en;
    logic              w_commit;
    logic [SUM_W-1:0]  w_sum_wide;
    logic [LEN_W-1:0]  w_len_sum;
    logic              w_meta_pop;
    logic              w_meta_empty;
    logic              w_meta_full_nxt;
    logic [LEN_W-1:0]  w_meta_len;
    logic [DATA_DEPTH_LOG2-1:0] w_rd_addr;
    beat_t             w_rd_beat;
    logic              w_unused;

    assign w_unused = ^s_axis.tuser;

    // Write side: full is judged on registered pointers only.
    assign w_accept   = s_axis.tvalid & r_s_tready;
    assign w_buf_full = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign w_wr_en    = w_accept & ~w_buf_full & ~r_ovf;
    assign w_sum_wide = {1'b0, r_byte_cnt} + SUM_W'(popcount8(s_axis.tstrb));
    assign w_len_sum  = w_sum_wide[LEN_W] ? {LEN_W{1'b1}} : w_sum_wide[LEN_W-1:0];
    assign w_commit   = w_accept & s_axis.tlast & ~s_axis.err & ~r_ovf & ~w_buf_full;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[DATA_DEPTH_LOG2-1:0]] <= '{tdata: s_axis.tdata,
                                                       tstrb: s_axis.tstrb,
                                                       tlast: s_axis.tlast};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_byte_cnt   <= '0;
            r_ovf        <= 1'b0;
            r_s_tready   <= 1'b0;
            r_good_cnt   <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_s_tready <= ~w_meta_full_nxt;
            if (w_accept) begin
                if (s_axis.tlast) begin
                    r_byte_cnt <= '0;
                    r_ovf      <= 1'b0;
                    if (w_commit) begin
                        r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
                        r_commit_ptr <= r_wr_ptr + PTR_W'(1);
                        r_good_cnt   <= r_good_cnt + 32'd1;
                    end else begin
                        r_wr_ptr   <= r_commit_ptr;
                        r_drop_cnt <= r_drop_cnt + 32'd1;
                    end
                end else begin
                    r_byte_cnt <= w_len_sum;
                    if (w_buf_full) begin
                        r_ovf <= 1'b1;
                    end else if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    end
                end
            end
        end
    end

    rx_tagger_meta_fifo #(
        .DEPTH_LOG2 (META_DEPTH_LOG2),
        .WIDTH      (LEN_W)
    ) u_meta_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_commit),
        .i_data       (w_len_sum),
        .i_pop        (w_meta_pop),
        .o_data_c     (w_meta_len),
        .o_empty_c    (w_meta_empty),
        .o_full_nxt_c (w_meta_full_nxt)
    );

    // Output register preloads the beat it will present next: rd_ptr in IDLE, rd_ptr+1 otherwise.
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
    assign w_rd_addr    = (r_state == IDLE) ? r_rd_ptr[DATA_DEPTH_LOG2-1:0]
                                            : w_rd_ptr_inc[DATA_DEPTH_LOG2-1:0];
    assign w_rd_beat    = r_mem[w_rd_addr];

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_meta_pop   = 1'b0;
        w_tvalid_nxt = r_m_tvalid;
        w_tdata_nxt  = r_m_tdata;
        w_tstrb_nxt  = r_m_tstrb;
        w_tlast_nxt  = r_m_tlast;
        w_tuser_nxt  = r_m_tuser;
        case (r_state)
            IDLE: begin
                if (!w_meta_empty) begin
                    w_meta_pop   = 1'b1;
                    w_state_nxt  = HEAD;
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = w_rd_beat.tdata;
                    w_tstrb_nxt  = w_rd_beat.tstrb;
                    w_tlast_nxt  = w_rd_beat.tlast;
                    w_tuser_nxt  = '0;
                    w_tuser_nxt[LEN_HI:LEN_LO] = w_meta_len;
                    w_tuser_nxt[SRC_HI:SRC_LO] = SRC_PORT;
                end
            end
            HEAD, BODY: begin
                if (m_axis.tready) begin
                    w_rd_ptr_nxt = w_rd_ptr_inc;
                    w_tuser_nxt  = '0;
                    if (r_m_tlast) begin
                        w_state_nxt  = IDLE;
                        w_tvalid_nxt = 1'b0;
                        w_tlast_nxt  = 1'b0;
                    end else begin
                        w_state_nxt  = BODY;
                        w_tdata_nxt  = w_rd_beat.tdata;
                        w_tstrb_nxt  = w_rd_beat.tstrb;
                        w_tlast_nxt  = w_rd_beat.tlast;
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
                w_tuser_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tstrb  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_m_tvalid <= w_tvalid_nxt;
            r_m_tdata  <= w_tdata_nxt;
            r_m_tstrb  <= w_tstrb_nxt;
            r_m_tlast  <= w_tlast_nxt;
            r_m_tuser  <= w_tuser_nxt;
        end
    end

    assign s_axis.tready = r_s_tready;
    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tstrb  = r_m_tstrb;
    assign m_axis.tlast  = r_m_tlast;
    assign m_axis.tuser  = r_m_tuser;
    assign m_axis.err    = 1'b0;
    assign pkt_good_cnt  = r_good_cnt;
    assign pkt_drop_cnt  = r_drop_cnt;

endmodule

// File: doc/rx_axis_len_tagger.md
Name: rx_axis_len_tagger

Overview:
- Store-and-forward stage directly downstream of the 10G RX queue, in the core clock domain.
- Buffers each incoming 64-bit AXI-Stream packet and counts its bytes. Packets flagged bad, or that overflow the buffer, are discarded.
- Good packets are re-emitted with NetFPGA 128-bit TUSER metadata on the first beat: packet length and source port.
- A packet is emitted only after its tlast beat has been accepted, so downstream never sees a partial packet.

Parameters:
- DATA_DEPTH_LOG2, 9, log2 of data buffer depth in 64-bit beats (512 beats = 4096 B).
- META_DEPTH_LOG2, 4, log2 of metadata FIFO depth in packets.
- SRC_PORT, 8'h01, one-hot port code written into tuser[23:16].

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- s_axis_tdata  in  64  input data
- s_axis_tstrb  in  8  byte enables, contiguous from LSB
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat
- s_axis_err  in  1  bad-frame flag, sampled only on the tlast beat
- m_axis_tdata  out  64  output data
- m_axis_tstrb  out  8  output byte enables
- m_axis_tuser  out  128  metadata; non-zero on first beat only
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- pkt_good_cnt  out  32  packets committed, wraps
- pkt_drop_cnt  out  32  packets dropped (bad or overflow), wraps

Behaviour:
- Reset: clock clk; reset is asynchronous, active-high.
  - All pointers, counters and state cleared.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0 while reset is high.
- Data buffer:
  - Circular RAM of 2^DATA_DEPTH_LOG2 entries x 73 bits (tdata, tstrb, tlast).
  - Pointers are DATA_DEPTH_LOG2+1 bits: wr_ptr, commit_ptr, rd_ptr.
  - full when wr_ptr - rd_ptr == depth.
- Write side:
  - s_axis_tready = ~meta_full.
  - Per accepted beat: byte_cnt += popcount(tstrb), using 16-bit saturating arithmetic.
  - If the buffer is not full, write the beat and increment wr_ptr.
  - If the buffer is full mid-packet, set ovf_flag, discard this and all remaining beats, and keep tready high.
- On accepted tlast:
  - Commit if s_axis_err=0 and ovf_flag=0, including the final beat fitting:
    - commit_ptr <= wr_ptr+1
    - push byte_cnt (final beat included) into the metadata FIFO
    - pkt_good_cnt++
  - Otherwise drop:
    - wr_ptr <= commit_ptr
    - pkt_drop_cnt++
  - In both cases byte_cnt and ovf_flag are cleared for the next cycle.
  - A single-beat packet (tvalid & tlast in the first beat) is legal.
- Read FSM states: IDLE, HEAD, BODY.
  - IDLE: when meta not empty, pop the length into len_reg and go to HEAD.
  - HEAD: m_axis_tvalid=1 with the beat at rd_ptr; tuser[15:0]=len_reg, tuser[23:16]=SRC_PORT, all other tuser bits 0.
  - BODY: same as HEAD but tuser=0.
  - On handshake: rd_ptr++. If the beat has tlast, go to IDLE; otherwise go to BODY.
- Read pointer never passes commit_ptr, guaranteed by the metadata gate.
- Outputs are registered, so m_axis_* holds stable while tvalid & ~tready.
- Latency: first output beat is valid no earlier than 2 cycles after the input tlast handshake.
- Throughput: one beat per cycle in steady state; one idle cycle between packets on the output (IDLE state) is permitted.
- Simultaneous read/write is allowed every cycle. A read freeing space in the same cycle as a write at full does not count as space: full is evaluated on registered pointers.
- Pointer wrap-around relies only on the extra MSB; no special case is needed.
- Reset mid-packet: both partial input and partial output packets are lost, and no truncated packet is emitted after reset.

Decomposition:
- Shared package rx_tagger_pkg:
  - TUSER field offsets: LEN_LO=0, LEN_HI=15, SRC_LO=16, SRC_HI=23.
  - Read FSM state encoding.
- Sub-module: rx_tagger_meta_fifo, a synchronous 16-bit x 2^META_DEPTH_LOG2 FIFO with full/empty flags.
- The data buffer with rewindable write pointer stays inline.

Test Plan:
- 64-byte good packet (8 beats, all tstrb=FF) -> 8 output beats; first tuser[15:0]=64, tuser[23:16]=01; tlast on beat 8; pkt_good_cnt=1.
- 61-byte packet (last tstrb=8'h1F) -> length 61; last output tstrb=1F.
- Bad packet (s_axis_err=1 on tlast) followed by a 60-byte good packet -> only the 60-byte packet appears; pkt_drop_cnt=1, pkt_good_cnt=1.
- DATA_DEPTH_LOG2=4, m_axis_tready=0, 20-beat packet, then tready=1 with a 2-beat packet -> 20-beat packet dropped, 2-beat packet emitted intact; drop_cnt=1.
- Random m_axis_tready (50%) over 100 back-to-back packets of random 1-1518 bytes -> output data/tstrb/length match a scoreboard exactly; no beat lost or duplicated.
- Assert reset during the 3rd beat of both an input packet and an output packet -> all outputs return to reset values; first packet after reset is emitted complete and correct.
